// File: rtl/ds1302_pkg.sv
// Shared types and command-byte helpers for the DS1302 3-wire transaction engine.
package ds1302_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CE_SETUP,
    ST_CMD,
    ST_WDATA,
    ST_RDATA,
    ST_TAIL,
    ST_CE_RECOV
  } state_t;

  localparam logic [7:0] CMD_MARK   = 8'h80;
  localparam logic [7:0] RAM_BIT    = 8'h40;
  localparam logic [4:0] BURST_ADDR = 5'h1F;
  localparam logic [7:0] WP_CMD     = 8'h8E;

  // Wire order is LSB first, so bit 0 (read/write flag) leaves the pin first.
  function automatic logic [7:0] build_cmd(input logic ram, input logic [4:0] a, input logic rd);
    return CMD_MARK | (ram ? RAM_BIT : 8'h00) | {2'b00, a, rd};
  endfunction

endpackage

// File: rtl/ds1302_tick_gen.sv
// SCLK half-period tick: one-cycle pulse every CLK_DIV cycles while enabled, phase restarted by clr.
module ds1302_tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk1,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_reg;

  assign tick = en && (cnt_reg == CW'(CLK_DIV - 1));

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      cnt_reg <= '0;
    end else if (clr || !en || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/ds1302_serial_engine.sv
// DS1302 CE/SCLK/IO transaction engine with start/busy/done handshake (single or burst, read or write).
// Define DS1302_AUTO_WP_EN to prefix every write with a write-protect clear frame (8'h8E then 8'h00).
module ds1302_serial_engine
  import ds1302_pkg::*;
#(
  parameter int CLK_DIV   = 1,
  parameter int MAX_BYTES = 8,
  parameter int CE_CYC    = 2
) (
  input  logic                             clk1,
  input  logic                             rstn,
  input  logic                             start,
  input  logic                             rw,
  input  logic                             burst,
  input  logic                             ram_sel,
  input  logic [4:0]                       addr,
  input  logic [$clog2(MAX_BYTES+1)-1:0]   nbytes,
  input  logic [8*MAX_BYTES-1:0]           wr_data,
  output logic [8*MAX_BYTES-1:0]           rd_data,
  output logic                             busy,
  output logic                             done,
  output logic                             CE,
  output logic                             SCLK,
  inout  wire                              IO
);

  localparam int NW = $clog2(MAX_BYTES + 1);
  localparam int BW = $clog2(8 * MAX_BYTES);
  localparam int DW = 8 * MAX_BYTES;
  localparam logic [7:0] CE_LAST = 8'(CE_CYC - 1);

  state_t          state;
  logic            ce_reg, sclk_reg, io_oe, io_out, busy_reg, done_reg, rw_lat;
  logic [DW-1:0]   rd_data_reg, wr_lat;
  logic [7:0]      cmd_lat, cur_cmd, ce_cnt;
  logic [NW-1:0]   len_lat, eff_len, cur_len;
  logic [BW-1:0]   bit_cnt, bit_nxt, last_bit;
  logic            tick, shifting, accept, wp_active, wr_bit0, wr_bit_nxt;

  assign accept   = (state == ST_IDLE) && start;
  assign shifting = (state == ST_CMD) || (state == ST_WDATA) || (state == ST_RDATA);

  ds1302_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk1 (clk1),
    .rstn (rstn),
    .clr  (accept),
    .en   (shifting),
    .tick (tick)
  );

  always_comb begin
    eff_len = NW'(1);
    if (burst) begin
      if (nbytes == '0)                  eff_len = NW'(1);
      else if (nbytes > NW'(MAX_BYTES))  eff_len = NW'(MAX_BYTES);
      else                               eff_len = nbytes;
    end
  end

`ifndef DS1302_AUTO_WP_EN
  assign wp_active = 1'b0;
`endif

  // While the write-protect prefix frame runs, command/length/data come from constants.
  assign cur_cmd    = wp_active ? WP_CMD : cmd_lat;
  assign cur_len    = wp_active ? NW'(1) : len_lat;
  assign bit_nxt    = bit_cnt + BW'(1);
  assign last_bit   = BW'({cur_len - NW'(1), 3'b111});
  assign wr_bit0    = wp_active ? 1'b0 : wr_lat[0];
  assign wr_bit_nxt = wp_active ? 1'b0 : wr_lat[bit_nxt];

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      ce_reg      <= 1'b0;
      sclk_reg    <= 1'b0;
      io_oe       <= 1'b0;
      io_out      <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      rw_lat      <= 1'b0;
      rd_data_reg <= '0;
      wr_lat      <= '0;
      cmd_lat     <= '0;
      len_lat     <= '0;
      bit_cnt     <= '0;
      ce_cnt      <= '0;
`ifdef DS1302_AUTO_WP_EN
      wp_active   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          rw_lat   <= rw;
          cmd_lat  <= build_cmd(ram_sel, burst ? BURST_ADDR : addr, rw);
          len_lat  <= eff_len;
          wr_lat   <= wr_data;
          if (rw) rd_data_reg <= '0;
`ifdef DS1302_AUTO_WP_EN
          wp_active <= ~rw;
`endif
          busy_reg <= 1'b1;
          ce_reg   <= 1'b1;
          ce_cnt   <= '0;
          state    <= ST_CE_SETUP;
        end
        ST_CE_SETUP: begin
          if (ce_cnt == CE_LAST) begin
            bit_cnt <= '0;
            io_oe   <= 1'b1;
            io_out  <= cur_cmd[0];
            state   <= ST_CMD;
          end else begin
            ce_cnt <= ce_cnt + 8'd1;
          end
        end
        ST_CMD: if (tick) begin
          if (!sclk_reg) begin
            sclk_reg <= 1'b1;
          end else begin
            sclk_reg <= 1'b0;
            if (bit_cnt[2:0] == 3'd7) begin
              bit_cnt <= '0;
              // The RTC starts driving on this falling edge, so let go of the line here.
              if (rw_lat) begin
                io_oe <= 1'b0;
                state <= ST_RDATA;
              end else begin
                io_out <= wr_bit0;
                state  <= ST_WDATA;
              end
            end else begin
              bit_cnt <= bit_nxt;
              io_out  <= cur_cmd[bit_cnt[2:0] + 3'd1];
            end
          end
        end
        ST_WDATA, ST_RDATA: if (tick) begin
          if (!sclk_reg) begin
            sclk_reg <= 1'b1;
            if (state == ST_RDATA) rd_data_reg[bit_cnt] <= IO;
          end else begin
            sclk_reg <= 1'b0;
            if (bit_cnt == last_bit) begin
              state <= ST_TAIL;
            end else begin
              bit_cnt <= bit_nxt;
              io_out  <= wr_bit_nxt;
            end
          end
        end
        ST_TAIL: begin
          ce_reg <= 1'b0;
          io_oe  <= 1'b0;
          ce_cnt <= '0;
          state  <= ST_CE_RECOV;
        end
        ST_CE_RECOV: begin
          if (ce_cnt == CE_LAST) begin
            if (wp_active) begin
`ifdef DS1302_AUTO_WP_EN
              wp_active <= 1'b0;
`endif
              ce_reg <= 1'b1;
              ce_cnt <= '0;
              state  <= ST_CE_SETUP;
            end else begin
              busy_reg <= 1'b0;
              done_reg <= 1'b1;
              state    <= ST_IDLE;
            end
          end else begin
            ce_cnt <= ce_cnt + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign IO      = io_oe ? io_out : 1'bz;
  assign CE      = ce_reg;
  assign SCLK    = sclk_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign rd_data = rd_data_reg;

endmodule
